// File: rtl/board_store.sv
// Clocked WIDTH x HEIGHT cell store for the game board.
// It has a write port, a registered bounds-checked read port, a clear sweep and a live occupancy count.
module board_store #(
  parameter  int WIDTH  = 8,
  parameter  int HEIGHT = 8,
  parameter  int CELL_W = 2,
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int CW     = $clog2(WIDTH*HEIGHT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [CELL_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_en,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic              rd_valid,
  output logic [CELL_W-1:0] rd_data,
  output logic              rd_oob,
  output logic [CW-1:0]     occupied
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_next;
  logic [CELL_W-1:0] cells [DEPTH];
  logic [AW-1:0]     clr_idx;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              wr_in, rd_in, wr_ok;
  logic [CELL_W-1:0] wr_old;

  assign wr_in  = (32'(wr_x) < 32'(WIDTH)) && (32'(wr_y) < 32'(HEIGHT));
  assign rd_in  = (32'(rd_x) < 32'(WIDTH)) && (32'(rd_y) < 32'(HEIGHT));
  assign wr_idx = AW'(32'(wr_y) * 32'(WIDTH) + 32'(wr_x));
  assign rd_idx = AW'(32'(rd_y) * 32'(WIDTH) + 32'(rd_x));
  assign wr_old = wr_in ? cells[wr_idx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_next = IDLE;
      IDLE:    if (clear_req)           state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy  = (state == CLEAR);
    wr_ok = (state == IDLE) && wr_en && wr_in && !clear_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx  <= '0;
      wr_err   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_oob   <= 1'b0;
      occupied <= '0;
    end else begin
      if (state == CLEAR)
        clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + AW'(1);
      else if (clear_req)
        clr_idx <= '0;

      // Occupancy tracks transitions between empty and non-empty only.
      if (state == IDLE && clear_req)
        occupied <= '0;
      else if (wr_ok) begin
        if (wr_old == '0 && wr_data != '0)
          occupied <= occupied + CW'(1);
        else if (wr_old != '0 && wr_data == '0)
          occupied <= occupied - CW'(1);
      end

      wr_err   <= wr_en && !wr_ok;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_oob  <= !rd_in;
        rd_data <= (busy || !rd_in) ? '0 : cells[rd_idx];
      end else begin
        rd_oob  <= 1'b0;
      end
    end
  end

  // Storage is not reset; the sweep zeroes it one cell per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      cells[clr_idx] <= '0;
    else if (wr_ok)
      cells[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_board_store.sv
// Randomised and directed bench for board_store.
// Two instances (8x8 and 5x3) are checked every cycle against a board-level reference model.
module tb_board_store;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       cr [2], we [2], re [2];
  logic [2:0] wx [2], wy [2], rx [2], ry [2];
  logic [1:0] wd [2];

  logic       busy_a, err_a, rv_a, oob_a, busy_b, err_b, rv_b, oob_b;
  logic [1:0] rd_a, rd_b;
  logic [6:0] occ_a;
  logic [3:0] occ_b;

  board_store #(.WIDTH(8), .HEIGHT(8), .CELL_W(2)) dut_a (
    .clk(clk), .reset(reset), .clear_req(cr[0]), .busy(busy_a),
    .wr_en(we[0]), .wr_x(wx[0]), .wr_y(wy[0]), .wr_data(wd[0]), .wr_err(err_a),
    .rd_en(re[0]), .rd_x(rx[0]), .rd_y(ry[0]), .rd_valid(rv_a), .rd_data(rd_a),
    .rd_oob(oob_a), .occupied(occ_a));

  board_store #(.WIDTH(5), .HEIGHT(3), .CELL_W(2)) dut_b (
    .clk(clk), .reset(reset), .clear_req(cr[1]), .busy(busy_b),
    .wr_en(we[1]), .wr_x(wx[1]), .wr_y(wy[1][1:0]), .wr_data(wd[1]), .wr_err(err_b),
    .rd_en(re[1]), .rd_x(rx[1]), .rd_y(ry[1][1:0]), .rd_valid(rv_b), .rd_data(rd_b),
    .rd_oob(oob_b), .occupied(occ_b));

  typedef struct {
    logic       busy, err, rv, oob;
    logic [1:0] rd;
    int         occ;
  } exp_t;

  exp_t qa[$], qb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: board contents, sweep cycles left, occupancy, held read data.
  int mw [2] = '{8, 5};
  int mh [2] = '{8, 3};
  int ym [2] = '{7, 3};
  int cells [2][64];
  int remaining [2];
  int mocc [2];
  logic [1:0] mrd [2];

  task automatic zero_board(input int d);
    for (int i = 0; i < 64; i++) cells[d][i] = 0;
  endtask

  task automatic model_tick(input int d, output exp_t e);
    int n, x, y, old;
    bit busy_now, inr, acc;
    n = mw[d] * mh[d];
    e.err = 1'b0; e.rv = 1'b0; e.oob = 1'b0;
    if (reset) begin
      remaining[d] = n;
      mocc[d] = 0;
      mrd[d] = 2'd0;
      zero_board(d);
    end else begin
      busy_now = remaining[d] > 0;
      if (re[d]) begin
        x = int'(rx[d]); y = int'(ry[d]) & ym[d];
        inr = (x < mw[d]) && (y < mh[d]);
        e.rv = 1'b1;
        e.oob = !inr;
        mrd[d] = (busy_now || !inr) ? 2'd0 : 2'(cells[d][y*mw[d] + x]);
      end
      x = int'(wx[d]); y = int'(wy[d]) & ym[d];
      inr = (x < mw[d]) && (y < mh[d]);
      acc = !busy_now && we[d] && inr && !cr[d];
      e.err = we[d] && !acc;
      if (acc) begin
        old = cells[d][y*mw[d] + x];
        if (old == 0 && wd[d] != 0) mocc[d]++;
        else if (old != 0 && wd[d] == 0) mocc[d]--;
        cells[d][y*mw[d] + x] = int'(wd[d]);
      end
      if (busy_now) remaining[d]--;
      else if (cr[d]) begin
        remaining[d] = n;
        mocc[d] = 0;
        zero_board(d);
      end
    end
    e.busy = remaining[d] > 0;
    e.rd = mrd[d];
    e.occ = mocc[d];
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_tick(0, e); qa.push_back(e);
    model_tick(1, e); qb.push_back(e);
    #1;
  endtask

  task automatic idle(input int d);
    cr[d] = 0; we[d] = 0; re[d] = 0;
    wx[d] = 0; wy[d] = 0; rx[d] = 0; ry[d] = 0; wd[d] = 0;
  endtask

  task automatic idle_all();
    idle(0); idle(1);
  endtask

  task automatic do_wr(input int d, input int x, input int y, input int v);
    we[d] = 1; wx[d] = 3'(x); wy[d] = 3'(y); wd[d] = 2'(v);
    tick();
    we[d] = 0;
  endtask

  task automatic do_rd(input int d, input int x, input int y);
    re[d] = 1; rx[d] = 3'(x); ry[d] = 3'(y);
    tick();
    re[d] = 0;
  endtask

  task automatic read_all_a();
    for (int i = 0; i < 64; i++) begin
      re[0] = 1; rx[0] = 3'(i % 8); ry[0] = 3'(i / 8);
      tick();
    end
    re[0] = 0;
  endtask

  task automatic cmp(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, d, $time, act, exp);
    end
  endtask

  task automatic check(input int d, input exp_t e);
    cmp("busy",     d, int'(d == 0 ? busy_a : busy_b), int'(e.busy));
    cmp("wr_err",   d, int'(d == 0 ? err_a  : err_b),  int'(e.err));
    cmp("rd_valid", d, int'(d == 0 ? rv_a   : rv_b),   int'(e.rv));
    cmp("rd_oob",   d, int'(d == 0 ? oob_a  : oob_b),  int'(e.oob));
    cmp("rd_data",  d, int'(d == 0 ? rd_a   : rd_b),   int'(e.rd));
    cmp("occupied", d, d == 0 ? int'(occ_a) : int'(occ_b), e.occ);
  endtask

  // Monitor: every cycle the DUTs present outputs, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin e = qa.pop_front(); check(0, e); end
      if (qb.size() > 0) begin e = qb.pop_front(); check(1, e); end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    idle_all();
    repeat (3) tick();
    reset = 1'b0;
    repeat (70) tick();

    // Read every cell of both boards, plus out-of-range rows on the 5x3.
    for (int i = 0; i < 64; i++) begin
      re[0] = 1; rx[0] = 3'(i % 8); ry[0] = 3'(i / 8);
      re[1] = (i < 32); rx[1] = 3'(i % 8); ry[1] = 3'((i / 8) % 4);
      tick();
    end
    idle_all();
    tick();

    do_wr(0, 3, 5, 2); do_rd(0, 3, 5);
    do_wr(0, 3, 5, 0); do_rd(0, 3, 5);
    do_wr(0, 3, 5, 2); do_wr(0, 3, 5, 3); do_rd(0, 3, 5);

    do_wr(1, 5, 0, 1); do_wr(1, 0, 3, 1); do_rd(1, 7, 2);
    do_wr(1, 4, 2, 1); do_rd(1, 4, 2);

    // Fill ten cells, then clear with a colliding write.
    for (int i = 0; i < 10; i++) do_wr(0, (i * 3) % 8, i / 3, 1 + i % 3);
    cr[0] = 1; we[0] = 1; wx[0] = 1; wy[0] = 1; wd[0] = 2;
    tick();
    idle(0);
    repeat (20) tick();
    cr[0] = 1; tick(); cr[0] = 0;
    do_wr(0, 0, 0, 1);
    repeat (45) tick();
    read_all_a();

    // Same-edge read and write of one cell.
    do_wr(0, 2, 2, 1);
    we[0] = 1; wx[0] = 2; wy[0] = 2; wd[0] = 3;
    re[0] = 1; rx[0] = 2; ry[0] = 2;
    tick();
    idle(0);
    do_rd(0, 2, 2);

    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        cr[d] = ($urandom_range(0, 99) == 0);
        we[d] = 1'($urandom_range(0, 1));
        wx[d] = 3'($urandom_range(0, 7));
        wy[d] = 3'($urandom_range(0, d == 0 ? 7 : 3));
        wd[d] = 2'($urandom_range(0, 3));
        re[d] = 1'($urandom_range(0, 1));
        rx[d] = 3'($urandom_range(0, 7));
        ry[d] = 3'($urandom_range(0, d == 0 ? 7 : 3));
      end
      tick();
    end
    idle_all();
    repeat (70) tick();

    // Asynchronous reset in the middle of a sweep.
    cr[0] = 1; tick(); cr[0] = 0;
    repeat (30) tick();
    reset = 1'b1;
    model_tick(0, e); qa[qa.size()-1] = e;
    model_tick(1, e); qb[qb.size()-1] = e;
    repeat (2) tick();
    reset = 1'b0;
    repeat (70) tick();
    do_wr(0, 7, 7, 2); do_rd(0, 7, 7);
    read_all_a();
    tick();

    @(negedge clk);
    #1;
    cmp("drain", 0, qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Parametrised, clocked cell store for the game board: WIDTH x HEIGHT cells, CELL_W bits each, addressed by (x, y).
- Adds a synchronous write port, a registered read port with bounds checking, a sequenced clear engine with busy flag, and a live count of non-empty cells.
- Sits between game-logic FSMs (writers) and the display/scan logic (reader); replaces the combinational reset-cleared board.

Parameters:
- WIDTH, 8, board columns; need not be a power of two.
- HEIGHT, 8, board rows; need not be a power of two.
- CELL_W, 2, bits per cell; value 0 means empty.
- XW, clog2(WIDTH) (min 1), derived x coordinate width.
- YW, clog2(HEIGHT) (min 1), derived y coordinate width.
- CW, clog2(WIDTH*HEIGHT+1), derived occupancy count width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- clear_req, input, 1, request full-board clear (sampled in IDLE only).
- busy, output, 1, high while the clear sweep runs.
- wr_en, input, 1, write strobe.
- wr_x, input, XW, write column.
- wr_y, input, YW, write row.
- wr_data, input, CELL_W, write value.
- wr_err, output, 1, one-cycle pulse when a write is rejected.
- rd_en, input, 1, read strobe.
- rd_x, input, XW, read column.
- rd_y, input, YW, read row.
- rd_valid, output, 1, read data valid (1 cycle after rd_en).
- rd_data, output, CELL_W, registered read data.
- rd_oob, output, 1, qualifies rd_valid; the read coordinate was out of range.
- occupied, output, CW, number of cells with non-zero value.

Behaviour:
- Addressing: index = y*WIDTH + x. A coordinate is in range iff x < WIDTH and y < HEIGHT. Out-of-range coordinates never touch the array.

Reset:
- reset=1 asynchronously forces: state=CLEAR, clr_idx=0, busy=1, wr_err=0, rd_valid=0, rd_data=0, rd_oob=0, occupied=0.
- Array contents are not reset directly; the clear sweep starts on the first clock edge after reset deasserts.
- Reset asserted mid-sweep or mid-operation restarts the sweep from index 0.

State machine (CLEAR, IDLE):
- CLEAR: each edge writes 0 to cell clr_idx and increments clr_idx. On the edge that writes index WIDTH*HEIGHT-1, state goes to IDLE and busy goes to 0. The sweep takes exactly WIDTH*HEIGHT cycles.
- Entering CLEAR from IDLE: on an edge with clear_req=1, state goes to CLEAR, busy=1, clr_idx=0, occupied=0. The first cell is cleared on the following edge.
- clear_req while in CLEAR is ignored; it neither restarts nor extends the sweep.
- IDLE: holds until clear_req.

Write port:
- Accepted when state=IDLE, wr_en=1, the coordinate is in range, and clear_req=0.
- clear_req wins over a simultaneous write; that write is rejected.
- A rejected write (busy, out of range, or pre-empted by clear_req) sets wr_err=1 on the next edge for exactly one cycle. Otherwise wr_err=0.
- Occupancy update on an accepted write (old = current cell value):
  - old==0 and wr_data!=0: occupied+1.
  - old!=0 and wr_data==0: occupied-1.
  - otherwise: no change.
- occupied never exceeds WIDTH*HEIGHT or goes below 0 by construction.

Read port:
- Latency 1: rd_en=1 at edge N gives rd_valid=1 after edge N, with rd_data and rd_oob valid in the same cycle.
- rd_en=0 at edge N gives rd_valid=0 and rd_oob=0 after edge N; rd_data holds its last value.
- Out-of-range read: rd_data=0, rd_oob=1.
- Read while busy: serviced, rd_data forced to 0, rd_oob per range check.
- Read and write to the same cell on the same edge: read-before-write; rd_data returns the old value.

Test Plan:
- Reset then idle, WIDTH=8, HEIGHT=8 -> busy=1 for exactly 64 cycles after reset deasserts, then 0; reading all 64 cells returns 0; occupied=0.
- In IDLE, write (3,5)=2 then rd_en (3,5) -> rd_valid=1 and rd_data=2 one cycle later; occupied=1. Overwrite with 0 -> occupied=0. Overwrite 2 with 3 -> occupied unchanged.
- WIDTH=5, HEIGHT=3: write x=5,y=0 and x=0,y=3 -> wr_err pulses for 1 cycle each, occupied unchanged. Read x=7,y=2 -> rd_oob=1, rd_data=0. Write (4,2)=1 -> readback 1 at index 14.
- Fill 10 cells, pulse clear_req together with wr_en -> write rejected (wr_err=1), occupied=0 next cycle, busy for 64 cycles. A second clear_req mid-sweep does not lengthen busy. A write during busy gives wr_err. All reads afterwards return 0.
- Same-edge write (2,2)=3 and read (2,2) over old value 1 -> rd_data=1. Next read -> 3.
- Assert reset mid-sweep at clr_idx=30 -> all outputs at reset values immediately (asynchronous). After release, busy lasts exactly 64 cycles, from index 0.
